// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, register address width and the
// write-counter limits used by the register file.
package cpu_pkg;

   localparam int DATA_W     = 16;
   localparam int REG_ADDR_W = 3;

   localparam int                WR_CNT_W   = 16;
   localparam logic [WR_CNT_W-1:0] WR_CNT_MAX = '1;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [DATA_W-1:0]     word_t;

endpackage

// File: rtl/reg_read_port.sv
// One combinational read port of the register file with write-through bypass.
// The bypass is held off during reset so reads show the stored array word.
module reg_read_port #(
   parameter int DATA_W = cpu_pkg::DATA_W,
   parameter int ADDR_W = cpu_pkg::REG_ADDR_W
) (
   input  logic              rst_n_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   input  logic [DATA_W-1:0] array_word_i,
   input  logic              reg_we_i,
   input  logic [ADDR_W-1:0] reg_waddr_i,
   input  logic [DATA_W-1:0] reg_source_i,
   output logic [DATA_W-1:0] rd_data_o
);

   // select the in-flight write word when it targets the addressed register
   always_comb begin
      rd_data_o = array_word_i;
      if (rst_n_i && reg_we_i && (rd_addr_i == reg_waddr_i)) begin
         rd_data_o = reg_source_i;
      end
   end

endmodule

// File: rtl/reg_file.sv
// General-purpose register file: one synchronous write port fed by the
// write-back mux, two bypassed combinational read ports, a per-register
// written flag and a saturating count of accepted writes.
module reg_file #(
   parameter int DATA_W   = cpu_pkg::DATA_W,
   parameter int NUM_REGS = 8,
   parameter int ADDR_W   = cpu_pkg::REG_ADDR_W
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                reg_we,
   input  logic [ADDR_W-1:0]   reg_waddr,
   input  logic [DATA_W-1:0]   reg_source,
   input  logic [ADDR_W-1:0]   ra_addr,
   input  logic [ADDR_W-1:0]   rb_addr,
   output logic [DATA_W-1:0]   ra_data,
   output logic [DATA_W-1:0]   rb_data,
   output logic [NUM_REGS-1:0] reg_written,
   output logic [15:0]         wr_count
);

   import cpu_pkg::*;

   logic [DATA_W-1:0]   regs_q [NUM_REGS];
   logic [DATA_W-1:0]   regs_d [NUM_REGS];
   logic [NUM_REGS-1:0] written_q;
   logic [NUM_REGS-1:0] written_d;
   logic [WR_CNT_W-1:0] wr_cnt_q;
   logic [WR_CNT_W-1:0] wr_cnt_d;

   // next state: apply the write, mark the target, bump the counter until full
   always_comb begin
      regs_d    = regs_q;
      written_d = written_q;
      wr_cnt_d  = wr_cnt_q;
      if (reg_we) begin
         regs_d[reg_waddr]    = reg_source;
         written_d[reg_waddr] = 1'b1;
         if (wr_cnt_q != WR_CNT_MAX) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
         end
      end
   end

   // state update; reset wins over a write in the same cycle
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
         written_q <= '0;
         wr_cnt_q  <= '0;
      end else begin
         regs_q    <= regs_d;
         written_q <= written_d;
         wr_cnt_q  <= wr_cnt_d;
      end
   end

   reg_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_port_a (
      .rst_n_i      (rst_n),
      .rd_addr_i    (ra_addr),
      .array_word_i (regs_q[ra_addr]),
      .reg_we_i     (reg_we),
      .reg_waddr_i  (reg_waddr),
      .reg_source_i (reg_source),
      .rd_data_o    (ra_data)
   );

   reg_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_port_b (
      .rst_n_i      (rst_n),
      .rd_addr_i    (rb_addr),
      .array_word_i (regs_q[rb_addr]),
      .reg_we_i     (reg_we),
      .reg_waddr_i  (reg_waddr),
      .reg_source_i (reg_source),
      .rd_data_o    (rb_data)
   );

   assign reg_written = written_q;
   assign wr_count    = wr_cnt_q;

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: reset contents, ordinary writes, same-cycle
// bypass on both ports, reset priority over a write, and counter saturation.
module tb_reg_file;

   logic        clk;
   logic        rst_n;
   logic        reg_we;
   logic [2:0]  reg_waddr;
   logic [15:0] reg_source;
   logic [2:0]  ra_addr;
   logic [2:0]  rb_addr;
   logic [15:0] ra_data;
   logic [15:0] rb_data;
   logic [7:0]  reg_written;
   logic [15:0] wr_count;

   int n_cmp;
   int n_bad;

   reg_file dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .reg_we      (reg_we),
      .reg_waddr   (reg_waddr),
      .reg_source  (reg_source),
      .ra_addr     (ra_addr),
      .rb_addr     (rb_addr),
      .ra_data     (ra_data),
      .rb_data     (rb_data),
      .reg_written (reg_written),
      .wr_count    (wr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_cmp      = 0;
      n_bad      = 0;
      rst_n      = 1'b0;
      reg_we     = 1'b0;
      reg_waddr  = '0;
      reg_source = '0;
      ra_addr    = '0;
      rb_addr    = '0;
      tick();
      tick();

      // reset contents on both ports
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         ra_addr = 3'(i);
         rb_addr = 3'(7 - i);
         #1;
         chk($sformatf("rst_ra%0d", i), {16'h0, ra_data}, 32'h0);
         chk($sformatf("rst_rb%0d", 7 - i), {16'h0, rb_data}, 32'h0);
      end
      chk("rst_written", {24'h0, reg_written}, 32'h0);
      chk("rst_count", {16'h0, wr_count}, 32'h0);

      // two consecutive writes
      reg_we = 1'b1; reg_waddr = 3'd3; reg_source = 16'h1234;
      tick();
      reg_waddr = 3'd7; reg_source = 16'hBEEF;
      tick();
      reg_we = 1'b0; reg_source = 16'h0000;
      ra_addr = 3'd3; rb_addr = 3'd7;
      #1;
      chk("wr_r3", {16'h0, ra_data}, 32'h1234);
      chk("wr_r7", {16'h0, rb_data}, 32'hBEEF);
      chk("wr_written", {24'h0, reg_written}, 32'h88);
      chk("wr_count2", {16'h0, wr_count}, 32'd2);

      // same-cycle bypass on both ports
      reg_we = 1'b1; reg_waddr = 3'd5; reg_source = 16'hA5A5;
      ra_addr = 3'd5; rb_addr = 3'd5;
      #1;
      chk("byp_a", {16'h0, ra_data}, 32'hA5A5);
      chk("byp_b", {16'h0, rb_data}, 32'hA5A5);
      chk("byp_count_pre", {16'h0, wr_count}, 32'd2);
      chk("byp_written_pre", {24'h0, reg_written}, 32'h88);
      tick();
      reg_we = 1'b0; reg_source = 16'h0000;
      #1;
      chk("stored_a", {16'h0, ra_data}, 32'hA5A5);
      chk("stored_b", {16'h0, rb_data}, 32'hA5A5);
      chk("count3", {16'h0, wr_count}, 32'd3);
      chk("written_a8", {24'h0, reg_written}, 32'hA8);

      // no-write bypass: address match without we reads stored data
      reg_waddr = 3'd3; reg_source = 16'hFFFF; ra_addr = 3'd3;
      #1;
      chk("nowe_r3", {16'h0, ra_data}, 32'h1234);

      // R0 is an ordinary register
      reg_we = 1'b1; reg_waddr = 3'd0; reg_source = 16'h0F0F;
      tick();
      reg_we = 1'b0; ra_addr = 3'd0; rb_addr = 3'd1;
      #1;
      chk("r0_data", {16'h0, ra_data}, 32'h0F0F);
      chk("r1_untouched", {16'h0, rb_data}, 32'h0);
      chk("r0_written", {24'h0, reg_written}, 32'hA9);

      // reset with a simultaneous write: bypass suppressed, write discarded
      rst_n = 1'b0; reg_we = 1'b1; reg_waddr = 3'd2; reg_source = 16'h5555;
      ra_addr = 3'd2; rb_addr = 3'd3;
      #1;
      chk("rstbyp_a", {16'h0, ra_data}, 32'h0);
      chk("rstbyp_b", {16'h0, rb_data}, 32'h1234);
      tick();
      rst_n = 1'b1; reg_we = 1'b0;
      #1;
      chk("rstwr_r2", {16'h0, ra_data}, 32'h0);
      chk("rstwr_r3", {16'h0, rb_data}, 32'h0);
      chk("rstwr_written", {24'h0, reg_written}, 32'h0);
      chk("rstwr_count", {16'h0, wr_count}, 32'h0);

      // first edge after reset release performs a write
      reg_we = 1'b1; reg_waddr = 3'd6; reg_source = 16'h00C3;
      tick();
      reg_we = 1'b0;
      ra_addr = 3'd6;
      #1;
      chk("post_rst_r6", {16'h0, ra_data}, 32'h00C3);
      chk("post_rst_count", {16'h0, wr_count}, 32'd1);

      // saturation: 65536 more writes to R1 (count starts at 1)
      reg_we = 1'b1; reg_waddr = 3'd1;
      for (int i = 0; i < 65536; i++) begin
         reg_source = 16'(i);
         if (i == 65533) begin
            #1;
            chk("sat_count_fffe", {16'h0, wr_count}, 32'hFFFE);
         end
         tick();
      end
      reg_we = 1'b0;
      ra_addr = 3'd1; rb_addr = 3'd6;
      #1;
      chk("sat_count", {16'h0, wr_count}, 32'hFFFF);
      chk("sat_r1", {16'h0, ra_data}, 32'hFFFF);
      chk("sat_r6", {16'h0, rb_data}, 32'h00C3);
      chk("sat_written", {24'h0, reg_written}, 32'h42);

      // saturated counter still lets the array and flags update
      reg_we = 1'b1; reg_waddr = 3'd4; reg_source = 16'h7E57;
      tick();
      reg_we = 1'b0; ra_addr = 3'd4;
      #1;
      chk("sat_r4", {16'h0, ra_data}, 32'h7E57);
      chk("sat_hold", {16'h0, wr_count}, 32'hFFFF);
      chk("sat_written2", {24'h0, reg_written}, 32'h52);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/reg_file.md
# reg_file

General-purpose register file of the 16-bit CPU, directly downstream of the write-back source mux. It captures the selected write-back word (ALU result or RAM data) on a clock edge and serves two combinational read ports to the operand-fetch and ALU stage. Reads of a register written in the same cycle are bypassed, so the value returned is the one being written.

## Interface
- `DATA_W`, 16: register and data width.
- `NUM_REGS`, 8: number of architectural registers.
- `ADDR_W`, 3: register address width; must equal clog2(`NUM_REGS`).

- `clk`, input, 1: system clock; all state updates on its rising edge.
- `rst_n`, input, 1: synchronous, active-low reset.
- `reg_we`, input, 1: write enable from the control unit.
- `reg_waddr`, input, `ADDR_W`: destination register.
- `reg_source`, input, `DATA_W`: write-back data from the write-back mux.
- `ra_addr`, input, `ADDR_W`: read port A address.
- `rb_addr`, input, `ADDR_W`: read port B address.
- `ra_data`, output, `DATA_W`: read port A data, combinational.
- `rb_data`, output, `DATA_W`: read port B data, combinational.
- `reg_written`, output, `NUM_REGS`: bit i = 1 once register i has been written since reset.
- `wr_count`, output, 16: number of accepted writes since reset; saturates at 0xFFFF.

## Operation
- Storage is `NUM_REGS` x `DATA_W` flops. R0 is an ordinary writable register; it is not hardwired to zero.
- **Write:**
  - On the rising edge with `rst_n`=1 and `reg_we`=1, the array entry at `reg_waddr` takes `reg_source`.
  - The same edge sets `reg_written[reg_waddr]`.
  - The same edge increments `wr_count` if it is below 0xFFFF.
- **No write:** with `reg_we`=0, all state holds.
- **Read:** `ra_data` equals regs[`ra_addr`], except when `reg_we`=1 and `ra_addr`==`reg_waddr`. In that case `ra_data` equals `reg_source` (write-through bypass). `rb_data` follows the same rule using `rb_addr`.
- Both ports may address the same register; both then return the same value, including the bypassed value.
- **Bypass during reset:** the bypass is suppressed while `rst_n`=0. Reads return the stored array contents.
- **Reset:** `rst_n`=0 sampled at a rising edge does the following:
  - clears every register to 0x0000;
  - sets `reg_written` to all zero;
  - sets `wr_count` to 0.
- Reset has priority over any simultaneous write; that write is discarded.
- **Counter saturation:** at 0xFFFF, further writes still update the array and `reg_written`, but `wr_count` holds.

## Timing
- Write latency: 1 cycle. Data written at edge N is visible from the stored array after edge N, and through the bypass during the cycle before edge N.
- Read latency: 0 cycles, combinational from address, `reg_we`, `reg_waddr` and `reg_source`.
- Reset values, from the first edge with `rst_n`=0:
  - all registers 0x0000;
  - `ra_data`/`rb_data` 0x0000;
  - `reg_written` 0;
  - `wr_count` 0.
- Reset asserted mid-stream takes effect on the next edge. Deassertion: the first edge with `rst_n`=1 may perform a write.
- No handshake: `reg_we` is a single-cycle qualifier, and each cycle with `reg_we`=1 is exactly one write.

## Structure
- The shared package `cpu_pkg` holds:
  - `DATA_W` = 16 and `REG_ADDR_W` = 3;
  - the typedef `reg_addr_t` of width `REG_ADDR_W`;
  - the typedef `word_t` of width `DATA_W`.
- The read-port bypass logic is instantiated twice as sub-module `reg_read_port`. Its inputs are address, array word, `reg_we`, `reg_waddr`, `reg_source` and `rst_n`; its output is the data.
- The array, `reg_written` and `wr_count` live in the top module.

## Test plan
- Reset, then read all 8 addresses on both ports: every read returns 0x0000, `reg_written`=0x00 and `wr_count`=0.
- Write 0x1234 to R3 and 0xBEEF to R7 in consecutive cycles, then read A=R3 and B=R7: A=0x1234, B=0xBEEF, `reg_written`=0x88, `wr_count`=2.
- In one cycle, set `reg_we`=1, `reg_waddr`=5, `reg_source`=0xA5A5 and `ra_addr`=`rb_addr`=5: both ports show 0xA5A5 in the same cycle. After the edge with `reg_we`=0, both still show 0xA5A5.
- Set `rst_n`=0 together with `reg_we`=1 writing 0x5555 to R2: after the edge, R2=0x0000, bit 2 of `reg_written` is 0 and `wr_count`=0.
- Perform 65,536 writes to R1 with an incrementing value: `wr_count` stays at 0xFFFF, and R1 holds the last value, 0xFFFF.
